// File: rtl/lamp_press_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : lamp_press_arbiter
// Purpose  : Round-robin sharing of the single lamp push-button among N_REQ
//            requesters. For each granted requester the block drives one
//            clean press/release pulse on btn, then checks that the lamp
//            output toggled and acknowledges the requester with done.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk      in   1      rising-edge clock
//   reset    in   1      asynchronous active-high reset
//   req      in   N_REQ  level requests, bit i = requester i wants a toggle
//   lamp_l   in   1      lamp output L fed back for the toggle check
//   btn      out  1      registered button drive to the lamp
//   grant    out  N_REQ  one-hot requester being served, 0 when idle
//   done     out  N_REQ  one-cycle pulse on the served bit at end of service
//   busy     out  1      high whenever the FSM is not idle
//   err      out  1      sticky flag: a service finished without an L toggle
//   clr_err  in   1      synchronous clear of err (a new failure wins)
// ============================================================================
module lamp_press_arbiter #(
  parameter int N_REQ          = 4,
  parameter int PRESS_CYCLES   = 2,
  parameter int RELEASE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic             lamp_l,
  input  logic             clr_err,
  output logic             btn,
  output logic [N_REQ-1:0] grant,
  output logic [N_REQ-1:0] done,
  output logic             busy,
  output logic             err
);

  // --------------------------------------------------------------------------
  // Sizing
  // --------------------------------------------------------------------------
  localparam int MAX_CYC = (PRESS_CYCLES > RELEASE_CYCLES) ? PRESS_CYCLES
                                                          : RELEASE_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;
  localparam int RR_W    = $clog2(N_REQ);

  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] PRESS_LAST   = CNT_W'(PRESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'(RELEASE_CYCLES - 1);
  localparam logic [RR_W-1:0]  RR_ONE       = RR_W'(1);
  localparam logic [RR_W-1:0]  RR_LAST      = RR_W'(N_REQ - 1);
  // One extra bit so rr + offset never overflows before the wrap subtract.
  localparam logic [RR_W:0]    N_REQ_EXT    = (RR_W+1)'(N_REQ);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESS   = 2'd1,
    RELEASE = 2'd2,
    CHECK   = 2'd3
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [RR_W-1:0]  rr, rr_n;
  logic             l_before, l_before_n;
  logic             btn_n;
  logic [N_REQ-1:0] grant_n;
  logic [N_REQ-1:0] done_n;
  logic             busy_n;
  logic             err_n;

  // --------------------------------------------------------------------------
  // Round-robin winner search
  // Scans offsets from the highest down to zero so that the smallest offset
  // from the rr pointer (i.e. the first set bit at or after rr, with wrap)
  // is the last one written and therefore wins.
  // --------------------------------------------------------------------------
  logic [RR_W:0]   search_idx;
  logic [RR_W-1:0] winner;
  logic            any_req;

  always_comb begin
    search_idx = '0;
    winner     = '0;
    any_req    = |req;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      search_idx = {1'b0, rr} + (RR_W+1)'(i);
      if (search_idx >= N_REQ_EXT) begin
        search_idx = search_idx - N_REQ_EXT;
      end
      if (req[search_idx[RR_W-1:0]]) begin
        winner = search_idx[RR_W-1:0];
      end
    end
  end

  // --------------------------------------------------------------------------
  // State and output registers. Every output is registered, so an async
  // reset drops btn/grant/busy immediately and suppresses any pending done.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      rr       <= '0;
      l_before <= 1'b0;
      btn      <= 1'b0;
      grant    <= '0;
      done     <= '0;
      busy     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      rr       <= rr_n;
      l_before <= l_before_n;
      btn      <= btn_n;
      grant    <= grant_n;
      done     <= done_n;
      busy     <= busy_n;
      err      <= err_n;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and next-output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    rr_n       = rr;
    l_before_n = l_before;
    btn_n      = btn;
    grant_n    = grant;
    done_n     = '0;
    // A failure detected in CHECK below overrides this clear.
    err_n      = err & ~clr_err;

    case (state)
      IDLE: begin
        btn_n   = 1'b0;
        grant_n = '0;
        if (any_req) begin
          grant_n         = '0;
          grant_n[winner] = 1'b1;
          l_before_n      = lamp_l;
          btn_n           = 1'b1;
          cnt_n           = '0;
          rr_n            = (winner == RR_LAST) ? '0 : winner + RR_ONE;
          state_n         = PRESS;
        end
      end

      PRESS: begin
        btn_n = 1'b1;
        if (cnt == PRESS_LAST) begin
          btn_n   = 1'b0;
          cnt_n   = '0;
          state_n = RELEASE;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end

      RELEASE: begin
        btn_n = 1'b0;
        if (cnt == RELEASE_LAST) begin
          done_n  = grant;
          state_n = CHECK;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end

      CHECK: begin
        // L has settled by now; an unchanged L means the press was lost.
        btn_n = 1'b0;
        if (lamp_l == l_before) begin
          err_n = 1'b1;
        end
        grant_n = '0;
        state_n = IDLE;
      end

      default: begin
        btn_n   = 1'b0;
        grant_n = '0;
        state_n = IDLE;
      end
    endcase

    busy_n = (state_n != IDLE);
  end

endmodule
`default_nettype wire

// File: tb/tb_lamp_press_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_lamp_press_arbiter
// Purpose  : Directed self-checking bench for lamp_press_arbiter with a
//            behavioural toggle lamp in the feedback loop.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lamp_press_arbiter;

  localparam int N = 4;
  localparam int P = 2;
  localparam int R = 2;

  logic         clk;
  logic         reset;
  logic [N-1:0] req;
  logic         clr_err;
  logic         btn;
  logic [N-1:0] grant;
  logic [N-1:0] done;
  logic         busy;
  logic         err;

  // Lamp model: L toggles on the first cycle B is sampled high.
  logic lamp_real;
  logic b_prev;
  logic lamp_force;
  logic forced_val;
  logic lamp_seen;

  int checks   = 0;
  int failures = 0;
  logic exp_lamp;

  assign lamp_seen = lamp_force ? forced_val : lamp_real;

  lamp_press_arbiter #(
    .N_REQ          (N),
    .PRESS_CYCLES   (P),
    .RELEASE_CYCLES (R)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .lamp_l  (lamp_seen),
    .clr_err (clr_err),
    .btn     (btn),
    .grant   (grant),
    .done    (done),
    .busy    (busy),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      lamp_real <= 1'b0;
      b_prev    <= 1'b0;
    end else begin
      b_prev <= btn;
      if (btn && !b_prev) lamp_real <= ~lamp_real;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called right after the req-sampling edge. Walks the 5 service cycles and
  // the following idle cycle, leaving the bench in that idle cycle.
  task automatic serve(input logic [N-1:0] g, input logic exp_err,
                       input logic clr_at_check);
    logic exp_seen;
    exp_lamp = ~exp_lamp;
    exp_seen = lamp_force ? forced_val : exp_lamp;
    chk("c1_grant", 32'(grant), 32'(g));
    chk("c1_btn",   32'(btn),   32'd1);
    chk("c1_busy",  32'(busy),  32'd1);
    tick();
    chk("c2_btn",   32'(btn),   32'd1);
    tick();
    chk("c3_btn",   32'(btn),   32'd0);
    chk("c3_done",  32'(done),  32'd0);
    tick();
    chk("c4_btn",   32'(btn),   32'd0);
    chk("c4_done",  32'(done),  32'd0);
    tick();
    chk("c5_done",  32'(done),  32'(g));
    chk("c5_grant", 32'(grant), 32'(g));
    chk("c5_btn",   32'(btn),   32'd0);
    chk("c5_lamp",  32'(lamp_seen), 32'(exp_seen));
    clr_err = clr_at_check;
    tick();
    clr_err = 1'b0;
    chk("c6_done",  32'(done),  32'd0);
    chk("c6_grant", 32'(grant), 32'd0);
    chk("c6_busy",  32'(busy),  32'd0);
    chk("c6_err",   32'(err),   32'(exp_err));
  endtask

  initial begin
    reset      = 1'b1;
    req        = '0;
    clr_err    = 1'b0;
    lamp_force = 1'b0;
    forced_val = 1'b0;
    exp_lamp   = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    // ---- reset state ----
    chk("rst_btn",   32'(btn),   32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_done",  32'(done),  32'd0);
    chk("rst_busy",  32'(busy),  32'd0);
    chk("rst_err",   32'(err),   32'd0);

    // ---- 1: single one-cycle request ----
    req = 4'b0001;
    tick();
    req = 4'b0000;
    serve(4'b0001, 1'b0, 1'b0);

    // ---- 2: all requesting, round-robin from a fresh pointer ----
    reset = 1'b1;
    #1;
    reset = 1'b0;
    exp_lamp = 1'b0;
    tick();
    req = 4'b1111;
    tick(); serve(4'b0001, 1'b0, 1'b0);
    tick(); serve(4'b0010, 1'b0, 1'b0);
    tick(); serve(4'b0100, 1'b0, 1'b0);
    tick(); serve(4'b1000, 1'b0, 1'b0);
    tick(); serve(4'b0001, 1'b0, 1'b0);
    tick(); serve(4'b0010, 1'b0, 1'b0);
    tick(); serve(4'b0100, 1'b0, 1'b0);

    // ---- 3: rr=3, req=0101 wraps to requester 0, then 2 ----
    req = 4'b0101;
    tick(); serve(4'b0001, 1'b0, 1'b0);
    tick(); serve(4'b0100, 1'b0, 1'b0);
    req = 4'b0000;
    tick();
    chk("idle_grant", 32'(grant), 32'd0);
    chk("idle_btn",   32'(btn),   32'd0);

    // ---- 4: lamp disconnected -> err, clear, clear vs new failure ----
    forced_val = lamp_real;
    lamp_force = 1'b1;
    req = 4'b0010;
    tick();
    req = 4'b0000;
    serve(4'b0010, 1'b1, 1'b0);
    tick();
    chk("err_sticky", 32'(err), 32'd1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("err_clr", 32'(err), 32'd0);
    req = 4'b0001;
    tick();
    req = 4'b0000;
    serve(4'b0001, 1'b1, 1'b1);
    lamp_force = 1'b0;

    // ---- 5: reset in cycle 2 of PRESS aborts at once ----
    req = 4'b0010;
    tick();
    req = 4'b0000;
    chk("abort_c1_btn", 32'(btn), 32'd1);
    tick();
    reset = 1'b1;
    #1;
    chk("abort_btn",   32'(btn),   32'd0);
    chk("abort_grant", 32'(grant), 32'd0);
    chk("abort_busy",  32'(busy),  32'd0);
    chk("abort_err",   32'(err),   32'd0);
    tick();
    tick();
    chk("abort_done",  32'(done),  32'd0);
    reset = 1'b0;
    exp_lamp = 1'b0;
    tick();
    chk("abort_nodone", 32'(done), 32'd0);
    req = 4'b0010;
    tick();
    req = 4'b0000;
    serve(4'b0010, 1'b0, 1'b0);

    // ---- 6: request dropped during PRESS still completes once ----
    req = 4'b0010;
    tick();
    req = 4'b0000;
    serve(4'b0010, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("no_regrant", 32'(grant), 32'd0);
      chk("no_redone",  32'(done),  32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
